comp_mult_stream: RTL and testbench

//  Streaming complex multiplier z = x*y or z = x*conj(y), full throughput (1 sample/clk), with valid/ready backpressure.
//  Per-sample rounding right-shift, saturate-or-wrap output and overflow flags. Sits between mixer/correlator stages
//  in the sample datapath; successor of the fixed-latency, no-backpressure complex multiplier.

---
 rtl/comp_mult_stream.sv | 123 ++++++++++++
 tb/tb_comp_mult_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/comp_mult_stream.sv
// comp_mult_stream: streaming complex multiplier z = x*y or x*conj(y) with valid/ready backpressure
// Four stages (operands, products, sums, round/shift/saturate); data registers on S1-S3 carry no reset.
module comp_mult_stream #(
  parameter int INPUT_WIDTH_I  = 18,
  parameter int INPUT_WIDTH_II = 18,
  parameter int OUTPUT_WIDTH   = 18,
  parameter int WRAP_SATURATE  = 1,
  parameter int SHIFT_WIDTH    = 6
) (
  input  logic                             i_clk,
  input  logic                             i_rst_p,
  input  logic signed [INPUT_WIDTH_I-1:0]  i_a,
  input  logic signed [INPUT_WIDTH_I-1:0]  i_b,
  input  logic signed [INPUT_WIDTH_II-1:0] i_c,
  input  logic signed [INPUT_WIDTH_II-1:0] i_d,
  input  logic                             i_conj,
  input  logic [SHIFT_WIDTH-1:0]           i_shift,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic signed [OUTPUT_WIDTH-1:0]   o_r,
  output logic signed [OUTPUT_WIDTH-1:0]   o_im,
  output logic                             o_ovf,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_ovf_sticky,
  input  logic                             i_clr_ovf
);
  localparam int IA   = INPUT_WIDTH_I;
  localparam int IC   = INPUT_WIDTH_II;
  localparam int OW   = OUTPUT_WIDTH;
  localparam int W    = IA + IC + 3;
  localparam int SMAX = IA + IC + 1;
  localparam logic signed [W:0] MAXV = {{(W - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [W:0] MINV = {{(W - OW + 2){1'b1}}, {(OW - 1){1'b0}}};
  logic r_v1, r_v2, r_v3, r_v4;
  logic w_en1, w_en2, w_en3, w_en4;
  logic signed [IA-1:0] r_a1, r_b1;
  logic signed [IC-1:0] r_c1;
  logic signed [IC:0]   r_d1, w_dn;
  logic signed [IA:0]   r_ab1, w_ab;
  logic signed [IC+1:0] r_cd1, w_cd;
  logic [SHIFT_WIDTH-1:0] r_sh1, r_sh2, r_sh3;
  logic signed [W-1:0] r_ac2, r_bd2, r_k2, r_zr3, r_zi3;
  logic [31:0] w_s;
  logic [OW:0] w_rr, w_ri;
  logic signed [OW-1:0] r_r, r_im;
  logic r_ovf, r_sticky;
  // Round half up, arithmetic shift, then clamp or wrap; returns {ovf, value}
  function automatic logic [OW:0] f_rnd(input logic signed [W-1:0] z, input logic [31:0] s);
    logic signed [W:0] h, v;
    logic hi, lo;
    h = (s == 0) ? '0 : (W + 1)'(1) << (s - 1);
    v = (W + 1)'(z) + h;
    v = v >>> s;
    hi = v > MAXV;
    lo = v < MINV;
    f_rnd = {hi | lo, (WRAP_SATURATE != 0 && hi) ? MAXV[OW-1:0] :
                      (WRAP_SATURATE != 0 && lo) ? MINV[OW-1:0] : v[OW-1:0]};
  endfunction
  assign w_en4   = !r_v4 | i_ready;
  assign w_en3   = !r_v3 | w_en4;
  assign w_en2   = !r_v2 | w_en3;
  assign w_en1   = !r_v1 | w_en2;
  assign o_ready = w_en1 & !i_rst_p;
  always_comb begin
    w_dn = i_conj ? -{i_d[IC-1], i_d} : {i_d[IC-1], i_d};
    w_ab = {i_a[IA-1], i_a} + {i_b[IA-1], i_b};
    w_cd = {{2{i_c[IC-1]}}, i_c} + {w_dn[IC], w_dn};
    w_s  = (32'(r_sh3) > 32'(SMAX)) ? 32'(SMAX) : 32'(r_sh3);
    w_rr = f_rnd(r_zr3, w_s);
    w_ri = f_rnd(r_zi3, w_s);
  end
  always_ff @(posedge i_clk) begin
    if (w_en1 & i_valid) begin
      r_a1  <= i_a;
      r_b1  <= i_b;
      r_c1  <= i_c;
      r_d1  <= w_dn;
      r_ab1 <= w_ab;
      r_cd1 <= w_cd;
      r_sh1 <= i_shift;
    end
    if (w_en2 & r_v1) begin
      r_ac2 <= W'(r_a1) * W'(r_c1);
      r_bd2 <= W'(r_b1) * W'(r_d1);
      r_k2  <= W'(r_ab1) * W'(r_cd1);
      r_sh2 <= r_sh1;
    end
    if (w_en3 & r_v2) begin
      r_zr3 <= r_ac2 - r_bd2;
      r_zi3 <= r_k2 - r_ac2 - r_bd2;
      r_sh3 <= r_sh2;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst_p) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_v4     <= 1'b0;
      r_r      <= '0;
      r_im     <= '0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= i_valid;
      if (w_en2) r_v2 <= r_v1;
      if (w_en3) r_v3 <= r_v2;
      if (w_en4) r_v4 <= r_v3;
      if (w_en4 & r_v3) begin
        r_r   <= w_rr[OW-1:0];
        r_im  <= w_ri[OW-1:0];
        r_ovf <= w_rr[OW] | w_ri[OW];
      end
      r_sticky <= (r_v4 & i_ready & r_ovf) | (r_sticky & !i_clr_ovf);
    end
  end
  assign o_r          = r_r;
  assign o_im         = r_im;
  assign o_valid      = r_v4;
  assign o_ovf        = r_ovf & r_v4;
  assign o_ovf_sticky = r_sticky;
endmodule

// File: tb/tb_comp_mult_stream.sv
// tb_comp_mult_stream: directed and random checks of comp_mult_stream against an arithmetic reference model
module tb_comp_mult_stream;
  localparam int IA = 18, IC = 18, OW = 18, WS = 1, SW = 6;
  typedef struct {longint r; longint im; bit ovf;} exp_t;
  logic clk = 0, rst = 1;
  logic signed [IA-1:0] i_a = 0, i_b = 0;
  logic signed [IC-1:0] i_c = 0, i_d = 0;
  logic i_conj = 0, i_valid = 0, i_ready = 1, i_clr_ovf = 0;
  logic [SW-1:0] i_shift = 0;
  logic o_ready, o_ovf, o_valid, o_ovf_sticky;
  logic signed [OW-1:0] o_r, o_im;
  exp_t q[$];
  int tot = 0, bad = 0, nout = 0;
  bit last_acc, last_ovf, sticky_m, saw_nready;
  longint last_r, last_im;

  always #5 clk = ~clk;

  comp_mult_stream #(.INPUT_WIDTH_I(IA), .INPUT_WIDTH_II(IC), .OUTPUT_WIDTH(OW),
                     .WRAP_SATURATE(WS), .SHIFT_WIDTH(SW)) dut (
    .i_clk(clk), .i_rst_p(rst), .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
    .i_conj(i_conj), .i_shift(i_shift), .i_valid(i_valid), .o_ready(o_ready),
    .o_r(o_r), .o_im(o_im), .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(i_ready),
    .o_ovf_sticky(o_ovf_sticky), .i_clr_ovf(i_clr_ovf));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fit(input longint v, output bit ovf);
    longint mx = (64'sd1 <<< (OW - 1)) - 1, mn = -(64'sd1 <<< (OW - 1)), w;
    ovf = (v > mx) || (v < mn);
    if (!ovf) return v;
    if (WS != 0) return (v > mx) ? mx : mn;
    w = v & ((64'sd1 <<< OW) - 1);
    return (w > mx) ? w - (64'sd1 <<< OW) : w;
  endfunction

  function automatic exp_t model(input longint a, b, c, d, input bit cj, input int sh);
    exp_t e;
    longint dd = cj ? -d : d;
    longint zr = a * c - b * dd, zi = a * dd + b * c;
    int s = (sh > IA + IC + 1) ? IA + IC + 1 : sh;
    longint h = (s > 0) ? (64'sd1 <<< (s - 1)) : 0;
    bit o1, o2;
    e.r = fit((zr + h) >>> s, o1);
    e.im = fit((zi + h) >>> s, o2);
    e.ovf = o1 | o2;
    return e;
  endfunction

  function automatic longint rnd_s(input int w);
    longint v = longint'($urandom) & ((64'sd1 <<< w) - 1);
    return (v >= (64'sd1 <<< (w - 1))) ? v - (64'sd1 <<< w) : v;
  endfunction

  task automatic tick();
    exp_t e;
    bit acc, xfer, eovf;
    #1;
    acc = i_valid && o_ready;
    xfer = o_valid && i_ready && !rst;
    eovf = 0;
    chk("o_ready", o_ready, (rst || (q.size() == 4 && !i_ready)) ? 0 : 1);
    if (!o_ready) saw_nready = 1;
    if (!rst) chk("valid_without_sample", o_valid && q.size() == 0, 0);
    if (xfer && q.size() > 0) begin
      e = q.pop_front();
      chk("o_r", o_r, e.r);
      chk("o_im", o_im, e.im);
      chk("o_ovf", o_ovf, e.ovf);
      last_r = o_r; last_im = o_im; last_ovf = o_ovf; eovf = e.ovf; nout++;
    end
    if (acc && !rst) q.push_back(model(i_a, i_b, i_c, i_d, i_conj, int'(i_shift)));
    if (rst) q.delete();
    sticky_m = rst ? 0 : (xfer && eovf) ? 1 : i_clr_ovf ? 0 : sticky_m;
    last_acc = acc && !rst;
    @(posedge clk);
    #1;
    chk("sticky", o_ovf_sticky, sticky_m);
  endtask

  task automatic send(input longint a, b, c, d, input bit cj, input int sh);
    int n = 0;
    i_a = IA'(a); i_b = IA'(b); i_c = IC'(c); i_d = IC'(d);
    i_conj = cj; i_shift = SW'(sh); i_valid = 1;
    do begin tick(); n++; end while (!last_acc && n < 20);
    chk("send_accepted", last_acc, 1);
    i_valid = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    i_valid = 0; i_ready = 1;
    while (q.size() > 0 && n < 30) begin tick(); n++; end
    chk(tag, q.size(), 0);
  endtask

  task automatic one(input string tag, input longint a, b, c, d, input bit cj, input int sh,
                     input longint er, ei, input bit eo);
    send(a, b, c, d, cj, sh);
    drain({tag, "_drain"});
    chk({tag, "_r"}, last_r, er);
    chk({tag, "_im"}, last_im, ei);
    chk({tag, "_ovf"}, last_ovf, eo);
  endtask

  initial begin
    int n, k, t, n0;
    longint sa[8], sb[8], sc[8], sd[8];
    rst = 1;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_r", o_r, 0);
    chk("rst_im", o_im, 0);
    chk("rst_ovf", o_ovf, 0);
    rst = 0;
    #1 chk("ready_after_rst", o_ready, 1);
    send(3, 4, 5, -2, 0, 0);
    n = 0;
    while (!o_valid && n < 10) begin tick(); n++; end
    chk("t1_latency", n + 1, 4);
    drain("t1_drain");
    chk("t1_r", last_r, 23);
    chk("t1_im", last_im, 14);
    chk("t1_ovf", last_ovf, 0);
    one("t2_conj", 3, 4, 5, -2, 1, 0, 7, 26, 0);
    one("t2_sat", 1, 0, 0, -131072, 1, 0, 0, WS ? 131071 : -131072, 1);
    one("t3_sh1", 3, 4, 5, -2, 0, 1, 12, 7, 0);
    one("t3_m3", -3, 0, 1, 0, 0, 1, -1, 0, 0);
    one("t3_m4", -4, 0, 1, 0, 0, 2, -1, 0, 0);
    one("t3_sh63", 300, -200, 100, 50, 0, 63, 0, 0, 0);
    i_clr_ovf = 1; tick(); i_clr_ovf = 0;
    chk("clr", o_ovf_sticky, 0);
    i_ready = 0;
    send(-131072, -131072, -131072, -131072, 0, 0);
    n = 0;
    while (!o_valid && n < 10) begin tick(); n++; end
    i_ready = 1; i_clr_ovf = 1;
    tick();
    i_clr_ovf = 0;
    chk("t4_r", last_r, 0);
    chk("t4_im", last_im, WS ? 131071 : 0);
    chk("t4_ovf", last_ovf, 1);
    chk("clr_set_wins", o_ovf_sticky, 1);
    for (int i = 0; i < 8; i++) begin
      sa[i] = rnd_s(IA); sb[i] = rnd_s(IA); sc[i] = rnd_s(IC); sd[i] = rnd_s(IC);
    end
    k = 0; t = 0; saw_nready = 0; n0 = nout;
    while (k < 8 && t < 40) begin
      i_a = IA'(sa[k]); i_b = IA'(sb[k]); i_c = IC'(sc[k]); i_d = IC'(sd[k]);
      i_conj = k[0]; i_shift = SW'(k * 3); i_valid = 1;
      i_ready = !(t >= 3 && t <= 6);
      tick();
      if (last_acc) k++;
      t++;
    end
    chk("t5_all_sent", k, 8);
    drain("t5_drain");
    chk("t5_ready_dropped", saw_nready, 1);
    chk("t5_count", nout - n0, 8);
    for (int i = 0; i < 3; i++) begin
      i_a = -131072; i_b = -131072; i_c = -131072; i_d = -131072;
      i_conj = 0; i_shift = 0; i_valid = 1;
      tick();
    end
    i_valid = 0; rst = 1;
    tick();
    rst = 0;
    #1 chk("t6_ready", o_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_valid", o_valid, 0);
    end
    chk("t6_sticky", o_ovf_sticky, 0);
    for (int i = 0; i < 200; i++) begin
      i_a = IA'(rnd_s(IA)); i_b = IA'(rnd_s(IA)); i_c = IC'(rnd_s(IC)); i_d = IC'(rnd_s(IC));
      i_conj = $urandom_range(0, 1) != 0;
      i_shift = SW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(16, 22));
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 2) != 0;
      i_clr_ovf = $urandom_range(0, 15) == 0;
      tick();
    end
    i_clr_ovf = 0;
    drain("rand_drain");
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
